// File: rtl/or_seq_pkg.sv
// Shared types and constants for the OR-gate truth-table sequencer.
// Holds the FSM state encoding, vector/counter widths and the golden
// response function used to build the expected-value table.
package or_seq_pkg;

    // Sequencer FSM states; only these three are ever reachable.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    // Truth table of a 2-input gate: four vectors, 2-bit index.
    localparam int NUM_VECTORS = 4;
    localparam int IDX_W       = 2;

    // Error counter holds 0..NUM_VECTORS without wrapping.
    localparam int ERR_W       = 3;

    // Index of the final vector of a run.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    // Golden response of an OR gate for a vector index.
    // Bit 0 of the index drives input A, bit 1 drives input B.
    function automatic logic or_expect(input logic [IDX_W-1:0] idx);
        return idx[0] | idx[1];
    endfunction

endpackage : or_seq_pkg

// File: rtl/or_vector_sequencer_hold_timer.sv
// Per-vector hold timer for the OR-gate sequencer.
// Counts DRIVE cycles from zero; o_tc flags the last cycle of a vector,
// which is the cycle whose closing edge samples the gate response.
// Load has priority over enable and returns the count to zero.
module hold_timer #(
    parameter  int HOLD_CYCLES = 4,
    localparam int CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_enable,
    output logic o_tc
);

    // Terminal value: last cycle a vector is held before sampling.
    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Hold counter: clear on reset or load, otherwise count while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // With HOLD_CYCLES=1 the count stays at zero, so every cycle is terminal.
    assign o_tc = (r_count == TC_VALUE);

endmodule : hold_timer

// File: rtl/or_vector_sequencer.sv
// Truth-table sequencer for a 2-input OR gate under test.
// On start it drives the vectors (a,b) = 00,10,01,11, holding each for
// HOLD_CYCLES cycles, samples the gate response on the last cycle of each
// vector and counts mismatches. done rises 4*HOLD_CYCLES cycles after the
// start edge; pass reports an error-free run.
// Build option: define OR_SEQ_STOP_ON_FAIL_EN to end the run on the first
// mismatching vector, leaving vec_idx on the failing index.
module or_vector_sequencer
    import or_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             dut_out,
    output logic [IDX_W-1:0] vec_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

`ifdef OR_SEQ_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    seq_state_t r_state;
    seq_state_t w_state_next;

    logic [IDX_W-1:0] r_vec_idx;
    logic [ERR_W-1:0] r_err_count;
    logic             r_a;
    logic             r_b;

    logic [NUM_VECTORS-1:0] w_expect_table;
    logic             w_expected;
    logic             w_in_drive;
    logic             w_tc;
    logic             w_sample;
    logic             w_mismatch;
    logic             w_start_run;
    logic             w_last_vec;
    logic             w_finish;
    logic [IDX_W-1:0] w_next_idx;

    // Golden truth table, one entry per vector index.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VECTORS; gi++) begin : g_expect
            assign w_expect_table[gi] = or_expect(IDX_W'(gi));
        end
    endgenerate

    assign w_expected  = w_expect_table[r_vec_idx];
    assign w_in_drive  = (r_state == ST_DRIVE);
    assign w_sample    = w_in_drive && w_tc;
    assign w_mismatch  = w_sample && (dut_out != w_expected);
    // start only matters outside DRIVE; a pulse mid-run is ignored.
    assign w_start_run = (r_state != ST_DRIVE) && start;
    assign w_last_vec  = (r_vec_idx == LAST_IDX);
    assign w_finish    = w_sample && (w_last_vec || (STOP_ON_FAIL && w_mismatch));
    assign w_next_idx  = r_vec_idx + 1'b1;

    // Hold timer is parked at zero outside DRIVE and rewinds after each sample.
    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (!w_in_drive || w_tc),
        .i_enable (w_in_drive),
        .o_tc     (w_tc)
    );

    // FSM state register; reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)    w_state_next = ST_DRIVE;
            ST_DRIVE: if (w_finish) w_state_next = ST_DONE;
            ST_DONE:  if (start)    w_state_next = ST_DRIVE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // Vector index, stimulus bits and error count, updated alongside the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_idx   <= '0;
            r_err_count <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
        end else if (w_start_run) begin
            // Vector 0 is 00, so the stimulus bits start low.
            r_vec_idx   <= '0;
            r_err_count <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
        end else if (w_sample) begin
            if (w_mismatch && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (w_finish) begin
                // Index stays on the last checked vector; stimulus returns low.
                r_a <= 1'b0;
                r_b <= 1'b0;
            end else begin
                r_vec_idx <= w_next_idx;
                r_a       <= w_next_idx[0];
                r_b       <= w_next_idx[1];
            end
        end
    end

    // FSM status outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (r_state)
            ST_DRIVE: busy = 1'b1;
            ST_DONE: begin
                done = 1'b1;
                pass = (r_err_count == '0);
            end
            default: ;
        endcase
    end

    assign a         = r_a;
    assign b         = r_b;
    assign vec_idx   = r_vec_idx;
    assign err_count = r_err_count;

endmodule : or_vector_sequencer

// File: doc/or_vector_sequencer.md
OR_VECTOR_SEQUENCER -- requirements
Module: or_vector_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: cycles each input vector is held (legal 1..255) SHALL be supported.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  begins a truth-table run when sampled high in IDLE or DONE.
REQ-005 a  output  1  registered stimulus bit A to the 2-input gate under test.
REQ-006 b  output  1  registered stimulus bit B to the gate under test.
REQ-007 dut_out  input  1  gate response, consumed by this block.
REQ-008 vec_idx  output  2  index of current vector; holds last-checked index in DONE.
REQ-009 busy  output  1  high while in DRIVE.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  valid when done=1: 1 iff err_count==0.
REQ-012 err_count  output  3  number of mismatching vectors in the current run (0..4).

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, DONE; no other reachable states.
REQ-014 IDLE: a=b=0, busy=done=pass=0; start=1 -> DRIVE, vec_idx<=0, hold_cnt<=0, err_count<=0.
REQ-015 In DRIVE, a SHALL equal vec_idx[0] and b SHALL equal vec_idx[1] (order 00,10,01,11).
REQ-016 hold_cnt SHALL increment each DRIVE cycle; at hold_cnt==HOLD_CYCLES-1, dut_out SHALL be sampled and compared to expected (a|b).
REQ-017 Mismatch SHALL increment err_count by 1 on the sample edge; err_count SHALL never wrap.
REQ-018 After the sample edge, vec_idx<3 -> vec_idx+1, hold_cnt<=0; vec_idx==3 -> DONE.
REQ-019 Latency: done SHALL rise exactly 4*HOLD_CYCLES cycles after the edge start was sampled.
REQ-020 DONE: a=b=0, done=1, pass=(err_count==0); outputs SHALL hold until start or rst.
REQ-021 start in DONE SHALL clear err_count and re-enter DRIVE at vec_idx 0 (same as REQ-014).
REQ-022 start while in DRIVE SHALL be ignored; run continues unaffected.
REQ-023 HOLD_CYCLES=1: sample SHALL occur on the first edge after vector is driven; no skipped vectors.

Reset
REQ-024 rst=1 SHALL force IDLE, a=b=0, vec_idx=0, hold_cnt=0, err_count=0, busy=done=pass=0 at next edge, from any state including mid-run.
REQ-025 rst SHALL dominate start when both are high.

Configuration
REQ-026 Macro OR_SEQ_STOP_ON_FAIL_EN defined: first mismatch SHALL transition directly to DONE on the sample edge, vec_idx holding the failing index, err_count=1.
REQ-027 Macro undefined: all four vectors SHALL always run regardless of mismatches.

Structure
REQ-028 Package or_seq_pkg SHALL hold the state enum, NUM_VECTORS=4, IDX_W=2, ERR_W=3.
REQ-029 Sub-module hold_timer (load, enable, terminal-count output, width from HOLD_CYCLES) SHALL implement hold_cnt.

Verification (HOLD_CYCLES=4 unless noted)
REQ-030 Golden OR gate, start pulse -> a/b sequence 00,10,01,11 each 4 cycles; done at +16 cycles, pass=1, err_count=0.
REQ-031 AND gate substituted -> err_count=2 (vectors 1,2), pass=0; with OR_SEQ_STOP_ON_FAIL_EN -> done at +8 cycles, vec_idx=1, err_count=1.
REQ-032 dut_out stuck-at-1 -> err_count=1, pass=0; with macro -> done at +4 cycles, vec_idx=0.
REQ-033 rst asserted at cycle 6 of a run -> next edge IDLE, all outputs zero; new start gives clean full run.
REQ-034 start re-pulsed during DRIVE then again in DONE -> first ignored; second restarts with err_count=0.
REQ-035 HOLD_CYCLES=1, golden OR -> done at +4 cycles, pass=1.
